// File: rtl/mmio_io_bridge_if.sv
// CPU-side memory-mapped bus of the I/O bridge: address, write data, strobes
// and the registered read data returned by the bridge.
interface mmio_io_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  // Handshake: cpu_we and cpu_re are single-cycle strobes with no
  // back-pressure; the bridge accepts every strobe. cpu_rdata is valid on the
  // cycle after cpu_re and holds until the next read strobe. When cpu_we and
  // cpu_re are both high, only the write takes effect.
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_re;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_addr,
    output cpu_wdata,
    output cpu_we,
    output cpu_re,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_addr,
    input  cpu_wdata,
    input  cpu_we,
    input  cpu_re,
    output cpu_rdata
  );
endinterface

// File: rtl/mmio_io_bridge.sv
// Memory-mapped I/O bridge: address decode, synchronous RAM, keypad FIFO with
// status/overflow, seven-segment register and key-available interrupt.
module mmio_io_bridge #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] MEM1_LO    = 16'h0000,
  parameter logic [ADDR_W-1:0] MEM1_HI    = 16'hcfff,
  parameter logic [ADDR_W-1:0] MEM2_LO    = 16'hf000,
  parameter logic [ADDR_W-1:0] MEM2_HI    = 16'hffff,
  parameter logic [ADDR_W-1:0] KEY_BASE   = 16'hd000,
  parameter logic [ADDR_W-1:0] SEG_ADDR   = 16'hd002,
  parameter logic [ADDR_W-1:0] CTRL_ADDR  = 16'hd003,
  parameter int                FIFO_DEPTH = 4,
  parameter int                KEY_W      = 4,
  parameter logic [DATA_W-1:0] UNMAPPED   = 16'hf345,
  parameter                    INIT_FILE  = "ram.ram"
) (
  input  logic              clk,
  input  logic              rst_n,
  mmio_io_bridge_if.slave   bus,
  input  logic              key_valid,
  input  logic [KEY_W-1:0]  key_code,
  output logic [DATA_W-1:0] seg_value,
  output logic              key_irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] KEY_STAT = ADDR_W'(KEY_BASE + 1'b1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

  // The RAM image named by INIT_FILE is loaded by the implementation flow;
  // the array itself carries no reset.
  if (INIT_FILE == "") begin : g_no_image
  end

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
  logic [KEY_W-1:0]  fifo [0:FIFO_DEPTH-1];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              irq_en;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_next;
  logic [DATA_W-1:0] status;

  logic wr_ev, rd_ev;
  logic is_ram, sel_key_data, sel_key_stat, sel_seg, sel_ctrl;
  logic non_empty, full, push, pop, ovf_set, ovf_clr;

  function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] lo,
                                    input logic [ADDR_W-1:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  assign is_ram       = in_range(bus.cpu_addr, MEM1_LO, MEM1_HI) ||
                        in_range(bus.cpu_addr, MEM2_LO, MEM2_HI);
  assign sel_key_data = !is_ram && (bus.cpu_addr == KEY_BASE);
  assign sel_key_stat = !is_ram && (bus.cpu_addr == KEY_STAT);
  assign sel_seg      = !is_ram && (bus.cpu_addr == SEG_ADDR);
  assign sel_ctrl     = !is_ram && (bus.cpu_addr == CTRL_ADDR);

  assign wr_ev = bus.cpu_we;
  assign rd_ev = bus.cpu_re && !bus.cpu_we;

  assign non_empty = (count != '0);
  assign full      = (count == CNT_FULL);
  assign pop       = rd_ev && sel_key_data && non_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the key.
  assign push      = key_valid && (!full || pop);
  assign ovf_set   = key_valid && full && !pop;
  assign ovf_clr   = wr_ev && sel_key_stat && bus.cpu_wdata[2];

  always_comb begin
    status        = '0;
    status[15:8]  = 8'(count);
    status[2]     = overflow;
    status[1]     = full;
    status[0]     = non_empty;
  end

  always_comb begin
    rdata_next = UNMAPPED;
    if (is_ram) begin
      rdata_next = mem[bus.cpu_addr];
    end else if (sel_key_data) begin
      rdata_next = non_empty ? DATA_W'(fifo[rd_ptr]) : '0;
    end else if (sel_key_stat) begin
      rdata_next = status;
    end else if (sel_seg) begin
      rdata_next = seg_value;
    end else if (sel_ctrl) begin
      rdata_next = DATA_W'(irq_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ev && is_ram) begin
      mem[bus.cpu_addr] <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= key_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q   <= '0;
      seg_value <= '0;
      irq_en    <= 1'b0;
      key_irq   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_ev && sel_seg) begin
        seg_value <= bus.cpu_wdata;
      end
      if (wr_ev && sel_ctrl) begin
        irq_en <= bus.cpu_wdata[0];
      end
      // A new drop outranks a clear issued on the same edge.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      if (rd_ev) begin
        rdata_q <= rdata_next;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      key_irq <= irq_en && non_empty;
    end
  end

  assign bus.cpu_rdata = rdata_q;

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Directed bench for mmio_io_bridge: decode, RAM, keypad FIFO, status,
// overflow, seven-segment register, interrupt and asynchronous reset.
module tb_mmio_io_bridge;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] seg_value;
  logic        key_irq;

  int checks   = 0;
  int failures = 0;

  mmio_io_bridge_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mmio_io_bridge dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .key_valid (key_valid),
    .key_code  (key_code),
    .seg_value (seg_value),
    .key_irq   (key_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: strobes are raised at the falling edge and results sampled
  // 1 time unit after the rising edge that consumes them.
  task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.cpu_addr  = addr;
    bus.cpu_wdata = data;
    bus.cpu_we    = 1'b1;
    @(posedge clk);
    #1;
    bus.cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] addr, output logic [15:0] data);
    @(negedge clk);
    bus.cpu_addr = addr;
    bus.cpu_re   = 1'b1;
    @(posedge clk);
    #1;
    data       = bus.cpu_rdata;
    bus.cpu_re = 1'b0;
  endtask

  task automatic push_key(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    if (bus.cpu_rdata !== 16'h0 || seg_value !== 16'h0 || key_irq !== 1'b0) begin
      $display("FAIL reset_outputs rdata=%h seg=%h irq=%b required 0/0/0",
               bus.cpu_rdata, seg_value, key_irq);
      failures++;
    end
    checks++;
    cpu_read(16'hd002, d);
    if (d !== 16'h0) begin $display("FAIL reset_seg got=%h exp=0000", d); failures++; end
    checks++;
    cpu_read(16'hd003, d);
    if (d !== 16'h0) begin $display("FAIL reset_ctrl got=%h exp=0000", d); failures++; end
    checks++;
    cpu_read(16'he000, d);
    if (d !== 16'hf345) begin $display("FAIL unmapped_e000 got=%h exp=f345", d); failures++; end
    checks++;
    cpu_read(16'hd004, d);
    if (d !== 16'hf345) begin $display("FAIL unmapped_d004 got=%h exp=f345", d); failures++; end
    checks++;
  endtask

  task automatic test_ram();
    logic [15:0] d;
    cpu_write(16'h0010, 16'h1234);
    cpu_read(16'h0010, d);
    if (d !== 16'h1234) begin $display("FAIL ram_0010 got=%h exp=1234", d); failures++; end
    checks++;
    cpu_write(16'he000, 16'h5555);
    cpu_read(16'he000, d);
    if (d !== 16'hf345) begin $display("FAIL unmapped_write got=%h exp=f345", d); failures++; end
    checks++;
    cpu_write(16'hcfff, 16'hcafe);
    cpu_write(16'hf000, 16'hbeef);
    cpu_read(16'hcfff, d);
    if (d !== 16'hcafe) begin $display("FAIL ram_cfff got=%h exp=cafe", d); failures++; end
    checks++;
    cpu_read(16'hf000, d);
    if (d !== 16'hbeef) begin $display("FAIL ram_f000 got=%h exp=beef", d); failures++; end
    checks++;
    cpu_read(16'h0010, d);
    if (d !== 16'h1234) begin $display("FAIL ram_0010_kept got=%h exp=1234", d); failures++; end
    checks++;
    // rdata holds while no read strobe is issued
    @(posedge clk); #1;
    if (bus.cpu_rdata !== 16'h1234) begin
      $display("FAIL rdata_hold got=%h exp=1234", bus.cpu_rdata); failures++;
    end
    checks++;
    // Write and read strobes together: write only, rdata unchanged
    @(negedge clk);
    bus.cpu_addr = 16'hd002; bus.cpu_wdata = 16'h00aa; bus.cpu_we = 1'b1; bus.cpu_re = 1'b1;
    @(posedge clk); #1;
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b0;
    if (seg_value !== 16'h00aa || bus.cpu_rdata !== 16'h1234) begin
      $display("FAIL we_re_same seg=%h rdata=%h exp seg=00aa rdata=1234",
               seg_value, bus.cpu_rdata); failures++;
    end
    checks++;
    cpu_read(16'hd002, d);
    if (d !== 16'h00aa) begin $display("FAIL seg_read got=%h exp=00aa", d); failures++; end
    checks++;
  endtask

  task automatic test_fifo_basic();
    logic [15:0] d;
    logic [15:0] exp_keys [3];
    exp_keys[0] = 16'h3; exp_keys[1] = 16'h7; exp_keys[2] = 16'ha;
    push_key(4'h3); push_key(4'h7); push_key(4'ha);
    cpu_read(16'hd001, d);
    if (d !== 16'h0301) begin $display("FAIL status_3 got=%h exp=0301", d); failures++; end
    checks++;
    for (int i = 0; i < 3; i++) begin
      cpu_read(16'hd000, d);
      if (d !== exp_keys[i]) begin
        $display("FAIL pop_%0d got=%h exp=%h", i, d, exp_keys[i]); failures++;
      end
      checks++;
    end
    cpu_read(16'hd001, d);
    if (d !== 16'h0000) begin $display("FAIL status_empty got=%h exp=0000", d); failures++; end
    checks++;
    cpu_read(16'hd000, d);
    if (d !== 16'h0000) begin $display("FAIL pop_empty got=%h exp=0000", d); failures++; end
    checks++;
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    for (int i = 1; i <= 5; i++) push_key(4'(i));
    cpu_read(16'hd001, d);
    if (d !== 16'h0407) begin $display("FAIL status_ovf got=%h exp=0407", d); failures++; end
    checks++;
    cpu_write(16'hd001, 16'h0004);
    cpu_read(16'hd001, d);
    if (d !== 16'h0403) begin $display("FAIL status_ovf_clr got=%h exp=0403", d); failures++; end
    checks++;
    for (int i = 1; i <= 4; i++) begin
      cpu_read(16'hd000, d);
      if (d !== 16'(i)) begin $display("FAIL ovf_pop_%0d got=%h exp=%h", i, d, 16'(i)); failures++; end
      checks++;
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] d;
    logic [15:0] exp_keys [4];
    exp_keys[0] = 16'h8; exp_keys[1] = 16'h7; exp_keys[2] = 16'h6; exp_keys[3] = 16'he;
    push_key(4'h9); push_key(4'h8); push_key(4'h7); push_key(4'h6);
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'he;
    bus.cpu_addr = 16'hd000; bus.cpu_re = 1'b1;
    @(posedge clk); #1;
    d = bus.cpu_rdata;
    key_valid = 1'b0; bus.cpu_re = 1'b0;
    if (d !== 16'h0009) begin $display("FAIL full_pushpop got=%h exp=0009", d); failures++; end
    checks++;
    cpu_read(16'hd001, d);
    if (d !== 16'h0403) begin $display("FAIL full_pushpop_status got=%h exp=0403", d); failures++; end
    checks++;
    for (int i = 0; i < 4; i++) begin
      cpu_read(16'hd000, d);
      if (d !== exp_keys[i]) begin
        $display("FAIL full_drain_%0d got=%h exp=%h", i, d, exp_keys[i]); failures++;
      end
      checks++;
    end
  endtask

  task automatic test_irq_and_reset();
    logic [15:0] d;
    cpu_write(16'hd003, 16'h0001);
    cpu_read(16'hd003, d);
    if (d !== 16'h0001) begin $display("FAIL ctrl_read got=%h exp=0001", d); failures++; end
    checks++;
    push_key(4'h2);
    if (key_irq !== 1'b0) begin $display("FAIL irq_early got=%b exp=0", key_irq); failures++; end
    checks++;
    @(posedge clk); #1;
    if (key_irq !== 1'b1) begin $display("FAIL irq_set got=%b exp=1", key_irq); failures++; end
    checks++;
    cpu_read(16'hd000, d);
    if (d !== 16'h0002 || key_irq !== 1'b1) begin
      $display("FAIL irq_pop data=%h irq=%b exp 0002/1", d, key_irq); failures++;
    end
    checks++;
    @(posedge clk); #1;
    if (key_irq !== 1'b0) begin $display("FAIL irq_clear got=%b exp=0", key_irq); failures++; end
    checks++;
    // Mid-burst reset with nonzero outputs everywhere
    cpu_write(16'hd002, 16'hbeef);
    push_key(4'h4); push_key(4'h5);
    cpu_read(16'hd002, d);
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'h6;
    bus.cpu_addr = 16'hd000; bus.cpu_re = 1'b1;
    if (bus.cpu_rdata !== 16'hbeef || seg_value !== 16'hbeef || key_irq !== 1'b1) begin
      $display("FAIL pre_reset rdata=%h seg=%h irq=%b exp beef/beef/1",
               bus.cpu_rdata, seg_value, key_irq); failures++;
    end
    checks++;
    #2 rst_n = 1'b0;
    #1;
    if (bus.cpu_rdata !== 16'h0 || seg_value !== 16'h0 || key_irq !== 1'b0) begin
      $display("FAIL async_reset rdata=%h seg=%h irq=%b exp 0/0/0",
               bus.cpu_rdata, seg_value, key_irq); failures++;
    end
    checks++;
    key_valid = 1'b0; bus.cpu_re = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cpu_read(16'hd001, d);
    if (d !== 16'h0000) begin $display("FAIL post_reset_status got=%h exp=0000", d); failures++; end
    checks++;
    cpu_read(16'hd003, d);
    if (d !== 16'h0000) begin $display("FAIL post_reset_ctrl got=%h exp=0000", d); failures++; end
    checks++;
  endtask

  initial begin
    rst_n         = 1'b0;
    key_valid     = 1'b0;
    key_code      = 4'h0;
    bus.cpu_addr  = 16'h0;
    bus.cpu_wdata = 16'h0;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    #23;
    rst_n = 1'b1;
    test_reset();
    test_ram();
    test_fifo_basic();
    test_overflow();
    test_full_push_pop();
    test_irq_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
